// File: rtl/gray_count_monitor_if.sv
// gray_count_monitor_if
//   Groups the sample input, the error-clear strobe and every result signal of
//   gray_count_monitor into one bundle.
//   master : the side that drives the gray samples and reads the results
//   slave  : the monitor itself
//   Signals:
//     g_valid, g_count   gray sample and its qualifier      (master -> slave)
//     err_clr            clears the error statistics        (master -> slave)
//     bin_valid, bin_count, step_err, wrap_pulse,
//     locked, err_sticky, err_cnt                           (slave -> master)
interface gray_count_monitor_if #(
   parameter int N         = 5,
   parameter int ERR_CNT_W = 8
);
   logic                 g_valid;
   logic [N-1:0]         g_count;
   logic                 err_clr;
   logic                 bin_valid;
   logic [N-1:0]         bin_count;
   logic                 step_err;
   logic                 wrap_pulse;
   logic                 locked;
   logic                 err_sticky;
   logic [ERR_CNT_W-1:0] err_cnt;

   modport master (
      output g_valid, g_count, err_clr,
      input  bin_valid, bin_count, step_err, wrap_pulse, locked, err_sticky, err_cnt
   );

   modport slave (
      input  g_valid, g_count, err_clr,
      output bin_valid, bin_count, step_err, wrap_pulse, locked, err_sticky, err_cnt
   );
endinterface

// File: rtl/gray_count_monitor.sv
// gray_count_monitor
//   Samples a gray-coded count, converts it to binary through a two-stage
//   registered pipeline and classifies every valid sample against the previous
//   one as hold, legal +1 step (with wrap) or illegal jump. Tracks a lock state
//   and keeps sticky / saturating error statistics.
//   Ports:
//     clk   rising-edge clock for all logic
//     srst  synchronous active-high reset, priority over every input
//     bus   gray_count_monitor_if.slave: g_valid/g_count/err_clr in,
//           bin_valid/bin_count/step_err/wrap_pulse/locked/err_sticky/err_cnt out
module gray_count_monitor #(
   parameter int N         = 5,
   parameter int ERR_CNT_W = 8,
   parameter int LOCK_N    = 4
) (
   input  logic                  clk,
   input  logic                  srst,
   gray_count_monitor_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_ACQUIRE = 2'd0,
      ST_RESYNC  = 2'd1,
      ST_TRACK   = 2'd2
   } state_t;

   localparam logic [3:0]           LOCK_TARGET = 4'(LOCK_N);
   localparam logic [N-1:0]         BIN_ONE     = {{(N-1){1'b0}}, 1'b1};
   localparam logic [ERR_CNT_W-1:0] ERR_ONE     = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

   // stage 1: raw sample
   logic                 s1_valid_q;
   logic [N-1:0]         s1_gray_q;

   // stage 2: results and tracking state
   state_t               state_q, state_d;
   logic [3:0]           good_q, good_d;
   logic [N-1:0]         ref_q, ref_d;
   logic                 bin_valid_q;
   logic [N-1:0]         bin_count_q;
   logic                 step_err_q, step_err_d;
   logic                 wrap_q, wrap_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 err_sticky_q, err_sticky_d;

   logic [N-1:0]         bin_w;
   logic [N-1:0]         ref_inc;
   logic                 is_hold;
   logic                 is_step;

   // Each binary bit is the XOR of all gray bits at or above it; written as a
   // reduction per bit so there is no combinational chain through bin_w.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_gray2bin
         assign bin_w[gi] = ^s1_gray_q[N-1:gi];
      end
   endgenerate

   assign ref_inc = ref_q + BIN_ONE;      // wraps naturally at 2^N
   assign is_hold = (bin_w == ref_q);
   assign is_step = (bin_w == ref_inc);

   always_comb begin
      state_d      = state_q;
      good_d       = good_q;
      ref_d        = ref_q;
      step_err_d   = 1'b0;
      wrap_d       = 1'b0;
      err_cnt_d    = err_cnt_q;
      err_sticky_d = err_sticky_q;

      if (s1_valid_q) begin
         ref_d = bin_w;
         case (state_q)
            ST_ACQUIRE: begin
               // first sample after reset only establishes the reference
               state_d = ST_RESYNC;
               good_d  = 4'd0;
            end
            ST_RESYNC: begin
               if (is_step) begin
                  good_d = good_q + 4'd1;
                  if (good_d == LOCK_TARGET) begin
                     state_d = ST_TRACK;
                  end
               end else if (!is_hold) begin
                  step_err_d = 1'b1;
                  good_d     = 4'd0;
               end
            end
            ST_TRACK: begin
               if (!is_step && !is_hold) begin
                  step_err_d = 1'b1;
                  good_d     = 4'd0;
                  state_d    = ST_RESYNC;
               end
            end
            default: begin
               state_d = ST_ACQUIRE;
               good_d  = 4'd0;
            end
         endcase
         wrap_d = (state_q == ST_RESYNC || state_q == ST_TRACK) && is_step && (ref_q == '1);
      end

      // a new error outranks a simultaneous clear: the count restarts at one
      if (step_err_d) begin
         err_sticky_d = 1'b1;
         if (bus.err_clr) begin
            err_cnt_d = ERR_ONE;
         end else if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
         end
      end else if (bus.err_clr) begin
         err_cnt_d    = '0;
         err_sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         s1_valid_q   <= 1'b0;
         s1_gray_q    <= '0;
         state_q      <= ST_ACQUIRE;
         good_q       <= 4'd0;
         ref_q        <= '0;
         bin_valid_q  <= 1'b0;
         bin_count_q  <= '0;
         step_err_q   <= 1'b0;
         wrap_q       <= 1'b0;
         err_cnt_q    <= '0;
         err_sticky_q <= 1'b0;
      end else begin
         s1_valid_q   <= bus.g_valid;
         s1_gray_q    <= bus.g_count;
         state_q      <= state_d;
         good_q       <= good_d;
         ref_q        <= ref_d;
         bin_valid_q  <= s1_valid_q;
         if (s1_valid_q) begin
            bin_count_q <= bin_w;
         end
         step_err_q   <= step_err_d;
         wrap_q       <= wrap_d;
         err_cnt_q    <= err_cnt_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   assign bus.bin_valid  = bin_valid_q;
   assign bus.bin_count  = bin_count_q;
   assign bus.step_err   = step_err_q;
   assign bus.wrap_pulse = wrap_q;
   assign bus.locked     = (state_q == ST_TRACK);
   assign bus.err_sticky = err_sticky_q;
   assign bus.err_cnt    = err_cnt_q;

endmodule

// File: doc/gray_count_monitor.md
Name: gray_count_monitor

Overview:
Downstream consumer of the gray-code counter output. Each cycle it samples the gray count and converts it to binary through a 2-stage registered pipeline. It classifies each sample against the previous one as hold, legal +1 step (including wrap) or illegal jump, and keeps lock state and error statistics. It sits between the gray counter and any logic that needs a binary count, or confidence that the count sequence is legal.

Parameters:
N, 5, gray/binary count width.
ERR_CNT_W, 8, width of the saturating error counter.
LOCK_N, 4, consecutive legal +1 steps required to (re)enter lock; range 1..15.

Ports:
clk  input  1  clock; all logic on its rising edge.
srst  input  1  synchronous reset, active-high.
g_valid  input  1  g_count is valid this cycle.
g_count  input  N  gray-coded count from the upstream counter.
err_clr  input  1  clears err_cnt and err_sticky.
bin_valid  output  1  bin_count and the classification flags are valid.
bin_count  output  N  binary equivalent of the sampled gray value.
step_err  output  1  1-cycle pulse with bin_valid: sample is an illegal transition.
wrap_pulse  output  1  1-cycle pulse with bin_valid: legal step from 2^N-1 to 0.
locked  output  1  1 while the FSM is in TRACK.
err_sticky  output  1  set on any step_err; cleared only by err_clr or srst.
err_cnt  output  ERR_CNT_W  count of step_err events; saturates at all-ones.

Behaviour:
- Reset (srst=1 at an edge): every output goes to 0; FSM goes to ACQUIRE; the good-step counter clears; the reference sample is invalidated; in-flight pipeline samples are dropped and no bin_valid is produced for them.
- Stage 1: g_valid and g_count are registered.
- Stage 2: the registered gray value is converted: b[N-1]=g[N-1], b[i]=b[i+1]^g[i]. bin_count, bin_valid, step_err, wrap_pulse, the FSM and the counters all update on the same edge.
- Latency: a sample presented with g_valid=1 before edge t appears on bin_valid/bin_count after edge t+1 (2 clocks). Throughput is one sample per cycle.
- g_valid=0: bin_valid=0 the following cycle after the pipeline; step_err and wrap_pulse stay 0; FSM, reference and good-step counter are unchanged. bin_count holds its last value.
- Classification of a valid sample, with binary value B against reference R:
  - HOLD: B==R.
  - STEP: B==(R+1) mod 2^N.
  - ERROR: anything else.
  - WRAP is the STEP case R=2^N-1, B=0; it asserts wrap_pulse.
  - After every valid sample, R is set to B, whatever the class.
- FSM:
  - ACQUIRE (no reference): the first valid sample only sets R, with no classification and no pulses -> RESYNC, good=0.
  - RESYNC: STEP increments good; HOLD leaves good unchanged; ERROR sets good=0. When good reaches LOCK_N -> TRACK. locked=0.
  - TRACK: HOLD and STEP stay in TRACK; ERROR -> RESYNC with good=0. locked=1.
- step_err asserts on ERROR in both RESYNC and TRACK.
- Any step_err sets err_sticky and increments err_cnt, saturating at 2^ERR_CNT_W-1.
- err_clr with no step_err in the same cycle: err_cnt=0, err_sticky=0.
- err_clr and step_err in the same cycle: the error wins; err_cnt=1, err_sticky=1.
- srst takes priority over every other input.

Test Plan:
1. Reset, then feed gray 0..31..0 (N=5) one per cycle, g_valid=1 → bin_count follows 0..31,0 with 2-cycle latency; locked=1 after the 5th sample (4 steps); wrap_pulse once at 31 (gray 10000) -> 0; step_err never.
2. Locked at binary 3 (gray 00010), then inject gray 00100 (binary 7) → bin_count=7; step_err pulse; err_cnt=1; err_sticky=1; locked drops; 4 further legal steps 8..11 re-lock.
3. Upstream counter reset mid-count: 19 then 0 held for 2 cycles, then 1,2,3,4 → one step_err at 0; the hold at 0 gives no error; locked returns after 4.
4. g_valid toggled 1,0,1,0 on consecutive steps 5,6,7 → bin_valid mirrors with 2-cycle delay; no errors; bin_count holds during gaps.
5. With err_cnt=255 (ERR_CNT_W=8), another error → err_cnt stays 255. err_clr on the same cycle as a new step_err → err_cnt=1, err_sticky=1.
6. srst asserted one cycle while samples are in flight → all outputs 0 the next cycle; no bin_valid for dropped samples; the first post-reset sample is not classified (ACQUIRE).
